// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_sequencer
// Description : Loads two NxN matrices (A then B) from a UART byte stream into
//               external memories. It then computes C = A x B, one element at
//               a time, saturating each element to 8 bits, and writes it to an
//               external C memory. Finally it streams C back out over a UART
//               transmitter in row-major order.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous reset, active low
//               rx_*       - received byte stream (one-cycle valid pulses)
//               a_we/b_we, wr_addr, wr_data   - A/B memory write port
//               a_/b_rd_addr, a_/b_rd_data    - A/B read ports (1-cycle latency)
//               c_we, c_addr, c_data          - C memory write port
//               c_rd_addr, c_rd_data          - C read port (1-cycle latency)
//               tx_data, tx_start, tx_busy    - UART transmitter handshake
//               state, done                   - status
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_sequencer #(
    parameter int N          = 10,
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  a_we,
    output logic                  b_we,
    output logic [6:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [6:0]            a_rd_addr,
    output logic [6:0]            b_rd_addr,
    input  logic [DATA_WIDTH-1:0] a_rd_data,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  c_we,
    output logic [6:0]            c_addr,
    output logic [7:0]            c_data,
    output logic [6:0]            c_rd_addr,
    input  logic [7:0]            c_rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic [2:0]            state,
    output logic                  done
);

    localparam logic [2:0] S_LOAD_A  = 3'd0;
    localparam logic [2:0] S_LOAD_B  = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [6:0] c_N      = 7'(N);
    localparam logic [6:0] c_NM1    = 7'(N - 1);
    localparam logic [6:0] c_LAST   = 7'(N * N - 1);
    localparam logic [6:0] c_K_LAST = 7'(N + 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [6:0]           r_load_cnt;
    logic [6:0]           r_row;
    logic [6:0]           r_col;
    logic [6:0]           r_k;          // element phase: 0..N-1 read, N+1 write
    logic [ACC_WIDTH-1:0] r_acc;
    logic [6:0]           r_idx;        // index of C element being transmitted
    logic                 r_send_phase; // 0: address issued, 1: read data valid
    logic                 r_seen_busy;
    logic [3:0]           r_tx_timer;
    logic [7:0]           r_tx_data;

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [7:0]              w_sat;
    logic                    w_last_elem;
    logic                    w_retry;
    logic                    w_unused_rx;

    // Only the low DATA_WIDTH bits of a received byte carry matrix data.
    assign w_unused_rx = &{1'b0, rx_data[7:DATA_WIDTH]};

    assign w_prod      = {{DATA_WIDTH{1'b0}}, a_rd_data} * {{DATA_WIDTH{1'b0}}, b_rd_data};
    assign w_sat       = (r_acc > ACC_WIDTH'(255)) ? 8'hFF : r_acc[7:0];
    assign w_last_elem = (r_row == c_NM1) && (r_col == c_NM1) && (r_k == c_K_LAST);
    // The transmitter never acknowledged the last start: pulse it again.
    assign w_retry     = !r_seen_busy && !tx_busy && (r_tx_timer == 4'd15);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD_A:  if (rx_valid && r_load_cnt == c_LAST) w_next = S_LOAD_B;
            S_LOAD_B:  if (rx_valid && r_load_cnt == c_LAST) w_next = S_COMPUTE;
            S_COMPUTE: if (w_last_elem) w_next = S_SEND;
            S_SEND:    if (r_send_phase && !tx_busy) w_next = S_WAIT_TX;
            S_WAIT_TX: if (r_seen_busy && !tx_busy)
                           w_next = (r_idx == c_LAST) ? S_DONE : S_SEND;
            S_DONE:    if (rx_valid) w_next = S_LOAD_A;
            default:   w_next = S_LOAD_A;
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters, accumulator and transmit holding register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_cnt   <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_k          <= '0;
            r_acc        <= '0;
            r_idx        <= '0;
            r_send_phase <= 1'b0;
            r_seen_busy  <= 1'b0;
            r_tx_timer   <= '0;
            r_tx_data    <= '0;
        end else begin
            case (r_state)
                S_LOAD_A, S_LOAD_B: begin
                    if (rx_valid) begin
                        r_load_cnt <= (r_load_cnt == c_LAST) ? 7'd0 : r_load_cnt + 7'd1;
                    end
                end
                S_COMPUTE: begin
                    // Product of the read issued in phase k-1 arrives in phase k.
                    if (r_k == 7'd0) begin
                        r_acc <= '0;
                    end else if (r_k <= c_N) begin
                        r_acc <= r_acc + ACC_WIDTH'(w_prod);
                    end
                    if (r_k == c_K_LAST) begin
                        r_k <= '0;
                        if (r_col == c_NM1) begin
                            r_col <= '0;
                            if (r_row == c_NM1) begin
                                r_row        <= '0;
                                r_idx        <= '0;
                                r_send_phase <= 1'b0;
                            end else begin
                                r_row <= r_row + 7'd1;
                            end
                        end else begin
                            r_col <= r_col + 7'd1;
                        end
                    end else begin
                        r_k <= r_k + 7'd1;
                    end
                end
                S_SEND: begin
                    if (!r_send_phase) begin
                        r_send_phase <= 1'b1;
                    end else if (!tx_busy) begin
                        r_tx_data    <= c_rd_data;
                        r_send_phase <= 1'b0;
                        r_seen_busy  <= 1'b0;
                        r_tx_timer   <= '0;
                    end
                end
                S_WAIT_TX: begin
                    if (tx_busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_seen_busy <= 1'b0;
                        if (r_idx != c_LAST) begin
                            r_idx <= r_idx + 7'd1;
                        end
                    end else if (w_retry) begin
                        r_tx_timer <= '0;
                    end else begin
                        r_tx_timer <= r_tx_timer + 4'd1;
                    end
                end
                S_DONE: begin
                    // The byte that leaves DONE is A[0] of the next run.
                    if (rx_valid) begin
                        r_load_cnt <= 7'd1;
                        r_idx      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        a_we      = 1'b0;
        b_we      = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        a_rd_addr = '0;
        b_rd_addr = '0;
        c_we      = 1'b0;
        c_addr    = '0;
        c_data    = '0;
        c_rd_addr = '0;
        tx_start  = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                a_we    = rx_valid;
                wr_addr = r_load_cnt;
                wr_data = rx_valid ? rx_data[DATA_WIDTH-1:0] : '0;
            end
            S_LOAD_B: begin
                b_we    = rx_valid;
                wr_addr = r_load_cnt;
                wr_data = rx_valid ? rx_data[DATA_WIDTH-1:0] : '0;
            end
            S_COMPUTE: begin
                if (r_k < c_N) begin
                    a_rd_addr = r_row * c_N + r_k;
                    b_rd_addr = r_k * c_N + r_col;
                end
                if (r_k == c_K_LAST) begin
                    c_we   = 1'b1;
                    c_addr = r_row * c_N + r_col;
                    c_data = w_sat;
                end
            end
            S_SEND: begin
                c_rd_addr = r_idx;
                tx_start  = r_send_phase && !tx_busy;
            end
            S_WAIT_TX: begin
                c_rd_addr = r_idx;
                tx_start  = w_retry;
            end
            S_DONE: begin
                done = 1'b1;
                if (rx_valid) begin
                    a_we    = 1'b1;
                    wr_data = rx_data[DATA_WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // Data is presented straight from C memory on the start cycle and held
    // from the latched copy afterwards.
    assign tx_data = (r_state == S_SEND && r_send_phase) ? c_rd_data : r_tx_data;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_sequencer
// Description : Self-checking bench for matmul_sequencer. Models the A/B/C
//               memories and a UART transmitter, feeds matrix bytes, and
//               compares transmitted results to a reference matrix product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;

    localparam int N  = 10;
    localparam int NN = N * N;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       a_we, b_we, c_we, tx_start, done;
    logic [6:0] wr_addr, a_rd_addr, b_rd_addr, c_addr, c_rd_addr;
    logic [3:0] wr_data;
    logic [3:0] a_rd_data = '0;
    logic [3:0] b_rd_data = '0;
    logic [7:0] c_data, tx_data;
    logic [7:0] c_rd_data = '0;
    logic       tx_busy = 1'b0;
    logic [2:0] state;

    matmul_sequencer #(.N(N), .DATA_WIDTH(4), .ACC_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
        .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
        .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .c_we(c_we), .c_addr(c_addr), .c_data(c_data),
        .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .state(state), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- memories and transmitter ----------------
    logic [3:0] mem_a [128];
    logic [3:0] mem_b [128];
    logic [7:0] mem_c [128];
    int         busy_left = 0;

    always @(posedge clk) begin
        if (a_we) mem_a[wr_addr] <= wr_data;
        if (b_we) mem_b[wr_addr] <= wr_data;
        if (c_we) mem_c[c_addr]  <= c_data;
        a_rd_data <= mem_a[a_rd_addr];
        b_rd_data <= mem_b[b_rd_addr];
        c_rd_data <= mem_c[c_rd_addr];
    end

    // Busy rises the cycle after a start and stays high 3..50 cycles.
    always @(posedge clk) begin
        if (tx_start && !tx_busy) begin
            tx_busy   <= 1'b1;
            busy_left <= int'($urandom_range(3, 50)) - 1;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    // ---------------- monitor ----------------
    int         c_writes, compute_cycles, tx_starts, viol;
    logic [7:0] tx_q [$];
    logic [7:0] held_tx = '0;
    logic       prev_c_we = 1'b0;
    logic       prev_tx_start = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (c_we) c_writes++;
            if (state == 3'd2) compute_cycles++;
            if (tx_start) begin
                tx_starts++;
                tx_q.push_back(tx_data);
                held_tx = tx_data;
                if (tx_busy) viol++;
            end
            if (state == 3'd4 && tx_data !== held_tx) viol++;
            if (a_we && b_we) viol++;
            if ((a_we || b_we) && (state == 3'd2 || state == 3'd3 || state == 3'd4)) viol++;
            if ((c_we && prev_c_we) || (tx_start && prev_tx_start)) viol++;
            if (a_rd_addr >= NN || b_rd_addr >= NN || c_addr >= NN ||
                c_rd_addr >= NN || wr_addr >= NN) viol++;
        end
        prev_c_we     = c_we;
        prev_tx_start = tx_start;
    end

    // ---------------- reference model ----------------
    int ref_a [NN];
    int ref_b [NN];
    int exp_c [NN];

    task automatic fill(input int mode);
        for (int i = 0; i < NN; i++) begin
            case (mode)
                0: begin ref_a[i] = 1;  ref_b[i] = 1;  end
                1: begin ref_a[i] = 15; ref_b[i] = 15; end
                2: begin ref_a[i] = (i / N == i % N) ? 1 : 0; ref_b[i] = i % 16; end
                default: begin
                    ref_a[i] = int'($urandom_range(0, 15));
                    ref_b[i] = int'($urandom_range(0, 15));
                end
            endcase
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) s += ref_a[r*N+k] * ref_b[k*N+c];
                exp_c[r*N+c] = (s > 255) ? 255 : s;
            end
        end
    endtask

    task automatic clear_stats();
        c_writes = 0; compute_cycles = 0; tx_starts = 0; viol = 0;
        tx_q.delete();
    endtask

    task automatic send_byte(input int v);
        logic [3:0] hi;
        @(negedge clk);
        hi       = 4'($urandom_range(0, 15));
        rx_data  = {hi, 4'(v)};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_all(input int start);
        for (int i = start; i < 2 * NN; i++) begin
            send_byte((i < NN) ? ref_a[i] : ref_b[i - NN]);
        end
    endtask

    // Waits for done; optionally sprinkles rx bytes while not loading.
    task automatic wait_done(input bit inject);
        int cyc;
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (inject && (state == 3'd2 || state == 3'd3 || state == 3'd4) &&
                $urandom_range(0, 5) == 0) begin
                rx_data  = 8'($urandom);
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic check_run(input string tag);
        $display("run %s", tag);
        chk("c_we_count", c_writes, NN);
        chk("compute_cycles", compute_cycles, NN * (N + 2));
        chk("tx_start_count", tx_starts, NN);
        chk("tx_bytes", tx_q.size(), NN);
        chk("protocol_viol", viol, 0);
        chk("done_flag", done, 1);
        for (int i = 0; i < NN && i < tx_q.size(); i++) begin
            chk("tx_byte", tx_q[i], exp_c[i]);
        end
    endtask

    initial begin
        int cyc;
        logic [3:0] hi;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_a_we", a_we, 0);
        chk("rst_b_we", b_we, 0);
        chk("rst_c_we", c_we, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rd_addr", a_rd_addr, 0);
        rst = 1'b1;

        // All ones
        fill(0); clear_stats(); send_all(0); wait_done(0); check_run("ones");

        // All 0xF: saturation
        fill(1); clear_stats(); send_all(0); wait_done(0); check_run("sat");

        // Identity x pattern
        fill(2); clear_stats(); send_all(0); wait_done(0); check_run("identity");

        // Random with rx noise while busy; first byte checked leaving DONE
        fill(3); clear_stats();
        @(negedge clk);
        hi       = 4'($urandom_range(0, 15));
        rx_data  = {hi, 4'(ref_a[0])};
        rx_valid = 1'b1;
        #1;
        chk("done_byte_a_we", a_we, 1);
        chk("done_byte_b_we", b_we, 0);
        chk("done_byte_addr", wr_addr, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("new_run_state", state, 0);
        chk("new_run_done", done, 0);
        send_all(1); wait_done(1); check_run("random_noise");

        // Reset during COMPUTE at element 37, then full reload
        fill(3); clear_stats(); send_all(0);
        cyc = 0;
        while (c_writes < 37 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_elem37", (c_writes >= 37) ? 1 : 0, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_c_we", c_we, 0);
        chk("midrst_rd_addr", a_rd_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_stats(); send_all(0); wait_done(0); check_run("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter: N, default 10, matrix dimension (N x N).
REQ-002 Parameter: DATA_WIDTH, default 4, element width of A and B.
REQ-003 Parameter: ACC_WIDTH, default 12, accumulator width.
REQ-004 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: rx_data  input  8  received UART byte.
REQ-007 Port: rx_valid  input  1  one-cycle pulse per received byte.
REQ-008 Port: a_we / b_we  output  1 each  write strobe into external A / B memory.
REQ-009 Port: wr_addr  output  7  A/B write address.
REQ-010 Port: wr_data  output  DATA_WIDTH  rx_data[DATA_WIDTH-1:0].
REQ-011 Port: a_rd_addr / b_rd_addr  output  7 each  read addresses, A/B memories, 1-cycle read latency.
REQ-012 Port: a_rd_data / b_rd_data  input  DATA_WIDTH each  read data.
REQ-013 Port: c_we  output  1  C memory write strobe; c_addr output 7; c_data output 8.
REQ-014 Port: c_rd_addr  output  7; c_rd_data input 8; C memory, 1-cycle read latency.
REQ-015 Port: tx_data  output  8; tx_start output 1 (one-cycle pulse); tx_busy input 1.
REQ-016 Port: state  output  3  current FSM state encoding; done output 1.

Function
REQ-017 FSM states: LOAD_A=0, LOAD_B=1, COMPUTE=2, SEND=3, WAIT_TX=4, DONE=5.
REQ-018 LOAD_A: each rx_valid -> a_we=1 same cycle, wr_addr=load count; after N*N bytes -> LOAD_B, count to 0.
REQ-019 LOAD_B: same as LOAD_A with b_we; after N*N bytes -> COMPUTE.
REQ-020 Upper 8-DATA_WIDTH bits of rx_data discarded; a_we/b_we never asserted together.
REQ-021 rx_valid in COMPUTE, SEND or WAIT_TX: ignored, no write, no count change.
REQ-022 COMPUTE: element (r,c) in row-major order; for k=0..N-1, one read per cycle: a_rd_addr=r*N+k, b_rd_addr=k*N+c.
REQ-023 Product a_rd_data*b_rd_data added to accumulator the cycle after its read issue; accumulator cleared at start of each element.
REQ-024 c_we one cycle after last product accumulated; c_addr=r*N+c; c_data=min(acc,255) saturated.
REQ-025 Each element exactly N+2 cycles; COMPUTE lasts exactly N*N*(N+2) cycles, then -> SEND with index 0.
REQ-026 Accumulator ACC_WIDTH bits; no overflow for N*(2^DATA_WIDTH-1)^2 at defaults (max 2250).
REQ-027 SEND: drive c_rd_addr=index; next cycle, once tx_busy=0, tx_data=c_rd_data and tx_start=1 for one cycle -> WAIT_TX.
REQ-028 WAIT_TX: hold until tx_busy sampled 1 then sampled 0; then increment index -> SEND, or -> DONE after index N*N-1.
REQ-029 tx_busy never asserted within 16 cycles of tx_start: tx_start reissued, error-free retry not required; stay in WAIT_TX.
REQ-030 tx_data held stable from tx_start until leaving WAIT_TX.
REQ-031 DONE: done=1; next rx_valid -> written as A[0], load count 1, done=0, state LOAD_A (new run).
REQ-032 Strobe outputs (a_we, b_we, c_we, tx_start) single-cycle; all addresses < N*N.

Reset
REQ-033 rst=0 asynchronously forces LOAD_A, all counters/accumulator 0, all outputs 0, any state including mid-COMPUTE and mid-WAIT_TX.
REQ-034 First rx_valid after rst release written as A[0].

Verification
REQ-035 2*N*N bytes, A=all 1, B=all 1 -> every C write c_data=10; 100 c_we pulses; 1200 COMPUTE cycles.
REQ-036 A=B=all 0xF -> acc 2250, every c_data=255 (saturated).
REQ-037 A=identity, B=row-major 0..99 mod 16 -> C equals B; tx bytes in order C[0]..C[99].
REQ-038 tx_busy model high 3..50 cycles after each tx_start -> exactly 100 tx_start pulses, never while tx_busy=1.
REQ-039 rst=0 during COMPUTE at element 37 -> state=0, c_we=0 same cycle; reload full data -> correct C.
REQ-040 rx_valid pulses during COMPUTE -> no a_we/b_we, results unchanged; byte in DONE -> a_we, wr_addr=0.
